counter_cmd_driver: RTL
=======================

COUNTER_CMD_DRIVER -- requirements
Module: counter_cmd_driver

Interface
REQ-001 SHALL have parameter N, default 8, meaning counter data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning command FIFO entries; must be a power of 2 and at least 2.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port abort  input  1  synchronous flush of the FIFO and the executing command.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  command can be accepted.
REQ-008 SHALL have port cmd_op  input  2  00 HOLD, 01 UP, 10 DOWN, 11 LOAD.
REQ-009 SHALL have port cmd_operand  input  N  repeat count minus 1 for HOLD/UP/DOWN; load value for LOAD.
REQ-010 SHALL have port control  output  2  registered control for the downstream counter.
REQ-011 SHALL have port parallel_in  output  N  registered load value for the downstream counter.
REQ-012 SHALL have port busy  output  1  a command is executing, or the FIFO is non-empty.
REQ-013 SHALL have port cmd_done  output  1  one-cycle pulse on the final cycle of each command.
REQ-014 SHALL have port shadow_count  output  N  expected downstream counter value.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse when shadow_count wraps.
REQ-016 SHALL have port level  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 SHALL accept a command on a clk edge when cmd_valid and cmd_ready are both 1, and write it into the FIFO.
REQ-018 SHALL drive cmd_ready = !full && !abort, with no combinational dependence on the same-cycle pop.
REQ-019 SHALL implement FSM states IDLE and EXEC.
REQ-020 SHALL, in IDLE with a non-empty FIFO, pop the head on the edge, load control<=op and remaining<=operand, load parallel_in<=operand (LOAD) or 0 (otherwise), and go to EXEC.
REQ-021 SHALL treat LOAD as a single cycle, with remaining forced to 0.
REQ-022 SHALL, in EXEC with remaining!=0, decrement remaining and hold control and parallel_in.
REQ-023 SHALL, in EXEC with remaining==0, assert cmd_done for that cycle, then on the edge pop and start the next command back-to-back if the FIFO is non-empty, else set control<=00, parallel_in<=0 and go to IDLE.
REQ-024 SHALL make a command with operand k drive its control value for exactly k+1 consecutive cycles; operand 2^N-1 gives 2^N cycles.
REQ-025 SHALL, on each edge while in EXEC, update shadow_count from the current control: +1 for UP, -1 for DOWN, =parallel_in for LOAD, unchanged for HOLD; arithmetic is modulo 2^N.
REQ-026 SHALL pulse wrap on the cycle after an UP from all-ones or a DOWN from zero; LOAD never sets wrap.
REQ-027 SHALL, on abort, empty the FIFO, set control<=00, parallel_in<=0, remaining<=0 and state<=IDLE on the next edge, with no cmd_done.
REQ-028 SHALL leave shadow_count applying the aborted cycle's control on the abort edge.
REQ-029 SHALL give abort priority over a simultaneous cmd_valid (command not accepted) and over any pop.
REQ-030 SHALL update level correctly on a simultaneous push and pop; a push into a full FIFO never occurs because of REQ-018.

Reset
REQ-031 SHALL, on rst_n low, immediately set state IDLE, FIFO empty, level 0, control 00, parallel_in 0, shadow_count 0, remaining 0, cmd_done 0, wrap 0, busy 0.
REQ-032 SHALL discard any executing or queued command when reset asserts mid-operation.
REQ-033 SHALL assert cmd_ready from the first edge after rst_n is released.

Structure
REQ-034 SHALL place the op encodings (HOLD/UP/DOWN/LOAD) and the FSM state enum in the shared package counter_pkg.
REQ-035 SHALL implement the FIFO as sub-module cmd_fifo, parameterised by width (2+N) and DEPTH, with push, pop, flush, full, empty and level.
REQ-036 SHALL remain synthesizable RTL of 120-400 lines total.

Verification
REQ-037 SHALL cover: LOAD 0x10, then UP operand 2 -> control 11 for 1 cycle, then 01 for 3 cycles; shadow_count 0x13; two cmd_done pulses.
REQ-038 SHALL cover: LOAD 0xFF, then UP operand 0 -> shadow_count 0x00, wrap pulses once.
REQ-039 SHALL cover: DOWN operand 0 from reset -> shadow_count 0xFF, wrap pulse.
REQ-040 SHALL cover: push 5 commands with no pops possible -> cmd_ready low after 4 accepted, level=4, 5th accepted only after the first pop.
REQ-041 SHALL cover: abort during UP operand 9 at cycle 3, with cmd_valid high -> control 00 next cycle, level 0, no cmd_done, command not accepted.
REQ-042 SHALL cover: rst_n low mid-DOWN -> all outputs 0 asynchronously; a counter instance driven by this block matches shadow_count on every cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter command driver: op encodings and FSM states.
package counter_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Power-of-two circular command FIFO with flush; head entry is visible on rdata_o.
module cmd_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [LW-1:0] count_q;
  logic          doPush;
  logic          doPop;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];
  assign doPush  = push_i && !full_o && !flush_i;
  assign doPop   = pop_i && !empty_o && !flush_i;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      unique case ({doPush, doPop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/counter_cmd_driver.sv
// Queues HOLD/UP/DOWN/LOAD commands and replays each as a timed control
// sequence for a downstream counter, while tracking that counter's value.
module counter_cmd_driver
  import counter_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   abort,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OP_W-1:0]        cmd_op,
  input  logic [N-1:0]           cmd_operand,
  output logic [OP_W-1:0]        control,
  output logic [N-1:0]           parallel_in,
  output logic                   busy,
  output logic                   cmd_done,
  output logic [N-1:0]           shadow_count,
  output logic                   wrap,
  output logic [$clog2(DEPTH):0] level
);

  logic              fifoFull;
  logic              fifoEmpty;
  logic              fifoPush;
  logic              fifoPop;
  logic [N+OP_W-1:0] fifoHead;
  op_e               headOp;
  logic [N-1:0]      headVal;
  logic [N-1:0]      startRemaining;
  logic [N-1:0]      startParallel;
  logic              lastCycle;

  state_e            state_q;
  op_e               control_q;
  logic [N-1:0]      parallelIn_q;
  logic [N-1:0]      remaining_q;
  logic              readyEn_q;
  logic [N-1:0]      shadow_q;
  logic [N-1:0]      shadow_d;
  logic              wrap_q;
  logic              wrap_d;

  cmd_fifo #(
    .W     (N + OP_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifoPush),
    .wdata_i ({cmd_op, cmd_operand}),
    .pop_i   (fifoPop),
    .flush_i (abort),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (level)
  );

  assign headOp  = op_e'(fifoHead[N+OP_W-1:N]);
  assign headVal = fifoHead[N-1:0];

  // LOAD is always a single cycle; the other ops repeat operand+1 times.
  assign startRemaining = (headOp == OP_LOAD) ? '0 : headVal;
  assign startParallel  = (headOp == OP_LOAD) ? headVal : '0;

  assign lastCycle = (state_q == ST_EXEC) && (remaining_q == '0);
  assign cmd_ready = readyEn_q && !fifoFull && !abort;
  assign fifoPush  = cmd_valid && cmd_ready;
  assign fifoPop   = !abort && !fifoEmpty && ((state_q == ST_IDLE) || lastCycle);
  assign cmd_done  = lastCycle && !abort;
  assign busy      = (state_q == ST_EXEC) || !fifoEmpty;

  assign control      = control_q;
  assign parallel_in  = parallelIn_q;
  assign shadow_count = shadow_q;
  assign wrap         = wrap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      control_q    <= OP_HOLD;
      parallelIn_q <= '0;
      remaining_q  <= '0;
      readyEn_q    <= 1'b0;
    end else begin
      readyEn_q <= 1'b1;
      if (abort) begin
        state_q      <= ST_IDLE;
        control_q    <= OP_HOLD;
        parallelIn_q <= '0;
        remaining_q  <= '0;
      end else if (fifoPop) begin
        state_q      <= ST_EXEC;
        control_q    <= headOp;
        parallelIn_q <= startParallel;
        remaining_q  <= startRemaining;
      end else if (state_q == ST_EXEC) begin
        if (remaining_q != '0) begin
          remaining_q <= remaining_q - N'(1);
        end else begin
          state_q      <= ST_IDLE;
          control_q    <= OP_HOLD;
          parallelIn_q <= '0;
        end
      end
    end
  end

  // The shadow follows whatever control is on the wire, including on an abort edge.
  always_comb begin
    shadow_d = shadow_q;
    wrap_d   = 1'b0;
    if (state_q == ST_EXEC) begin
      unique case (control_q)
        OP_UP: begin
          shadow_d = shadow_q + N'(1);
          wrap_d   = &shadow_q;
        end
        OP_DOWN: begin
          shadow_d = shadow_q - N'(1);
          wrap_d   = ~|shadow_q;
        end
        OP_LOAD: shadow_d = parallelIn_q;
        default: shadow_d = shadow_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      wrap_q   <= wrap_d;
    end
  end

endmodule
